// File: rtl/even_odd_pkg.sv
// Shared definitions for the even-ones / consecutive-zeros link:
// transmitter FSM encoding, detector FSM encoding and frame-length helper.
package even_odd_pkg;

    // Transmitter states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_TERM  = 2'd3
    } tx_state_e;

    // Detector states: parity of ones seen so far crossed with the trailing-zero run.
    typedef enum logic [1:0] {
        DET_EVEN      = 2'd0,
        DET_ODD       = 2'd1,
        DET_EVEN_Z1   = 2'd2,
        DET_EVEN_ZZ   = 2'd3
    } det_state_e;

    localparam int BUSY_W = 6;
    localparam int CNT_W  = 5;

    // Total frame length: payload, one parity bit, then the zero terminator.
    function automatic int frame_len(input int data_w, input int term_zeros);
        return data_w + 1 + term_zeros;
    endfunction

    localparam int FRAME_LEN_DEFAULT = frame_len(8, 2);

endpackage

// File: rtl/even_odd_seq_tx.sv
// Serial frame transmitter: MSB-first payload, even-parity bit, then a run of
// zeros. All outputs come from registered state only.
module even_odd_seq_tx
    import even_odd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TERM_ZEROS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              x,
    output logic              x_valid,
    output logic              done,
    output logic [BUSY_W-1:0] busy_bits
);

    localparam int                FRAME_LEN = frame_len(DATA_W, TERM_ZEROS);
    localparam logic [BUSY_W-1:0] BUSY_INIT = BUSY_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_SHIFT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_TERM  = CNT_W'(TERM_ZEROS - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q,   par_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [BUSY_W-1:0] busy_q,  busy_d;
    logic              done_q,  done_d;

    // Next-state logic: handshake, shifting, parity accumulation and counters.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    shift_d = data;
                    par_d   = 1'b0;
                    cnt_d   = CNT_SHIFT;
                    busy_d  = BUSY_INIT;
                end
            end
            ST_SHIFT: begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                par_d   = par_q ^ shift_q[DATA_W-1];
                busy_d  = busy_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_PAR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PAR: begin
                state_d = ST_TERM;
                cnt_d   = CNT_TERM;
                busy_d  = busy_q - 1'b1;
            end
            ST_TERM: begin
                busy_d = busy_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers: reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Datapath registers: only meaningful once loaded on acceptance.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        cnt_q   <= cnt_d;
    end

    // Output decode from registered state.
    always_comb begin
        ready     = (state_q == ST_IDLE);
        x_valid   = (state_q != ST_IDLE);
        done      = done_q;
        busy_bits = busy_q;
        x         = 1'b0;
        case (state_q)
            ST_SHIFT: x = shift_q[DATA_W-1];
            ST_PAR:   x = par_q;
            default:  x = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_even_odd_seq_tx.sv
// Self-checking bench for even_odd_seq_tx with a frame-queue reference model.
module tb_even_odd_seq_tx;
    localparam int DATA_W     = 8;
    localparam int TERM_ZEROS = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              x;
    logic              x_valid;
    logic              done;
    logic [5:0]        busy_bits;

    int total = 0;
    int bad   = 0;

    // Reference model: the remaining bits of the frame in flight.
    bit exp_q[$];
    bit exp_done;

    // Observed-frame capture for directed checks.
    logic [63:0] cap;
    int          cap_n;
    logic [63:0] last_frame;
    int          last_len;
    int          done_cnt;
    int          ones;

    even_odd_seq_tx #(.DATA_W(DATA_W), .TERM_ZEROS(TERM_ZEROS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data      (data),
        .ready     (ready),
        .x         (x),
        .x_valid   (x_valid),
        .done      (done),
        .busy_bits (busy_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the behavioural model, using the inputs applied for this edge.
    task automatic model_step();
        if (reset) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else if (exp_q.size() == 0) begin
            exp_done = 1'b0;
            if (start) begin
                for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(data[i]);
                exp_q.push_back(^data);
                for (int i = 0; i < TERM_ZEROS; i++) exp_q.push_back(1'b0);
            end
        end else begin
            void'(exp_q.pop_front());
            exp_done = (exp_q.size() == 0);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        check("ready",     {63'd0, ready},     {63'd0, sz == 0});
        check("x_valid",   {63'd0, x_valid},   {63'd0, sz != 0});
        check("x",         {63'd0, x},         {63'd0, (sz != 0) ? exp_q[0] : 1'b0});
        check("done",      {63'd0, done},      {63'd0, exp_done});
        check("busy_bits", {58'd0, busy_bits}, 64'(sz));
        if (x_valid === 1'b1) begin
            cap   = {cap[62:0], x};
            cap_n = cap_n + 1;
        end
        if (done === 1'b1) begin
            last_frame = cap;
            last_len   = cap_n;
            done_cnt   = done_cnt + 1;
            cap        = '0;
            cap_n      = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [DATA_W-1:0] d);
        reset = r;
        start = s;
        data  = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (r) begin
            cap   = '0;
            cap_n = 0;
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d);
        cyc(1'b0, 1'b1, d);
        for (int i = 0; i < DATA_W + 1 + TERM_ZEROS + 1; i++) cyc(1'b0, 1'b0, $urandom);
    endtask

    initial begin
        cap = '0; cap_n = 0; last_frame = '0; last_len = 0; done_cnt = 0;
        exp_done = 1'b0;

        // Reset then idle.
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0);

        // Directed frames.
        send_frame(8'hA5);
        check("a5_frame", last_frame, 64'b10100101000);
        check("a5_len",   64'(last_len), 64'd11);

        send_frame(8'h07);
        check("07_frame", last_frame, 64'b00000111100);
        ones = $countones(last_frame);
        check("07_ones",  64'(ones), 64'd4);

        // Start with different data mid-frame is ignored.
        done_cnt = 0;
        cyc(1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'hFF);
        check("01_frame", last_frame, 64'b00000001100);
        check("01_dones", 64'(done_cnt), 64'd1);

        // Reset during the 4th SHIFT cycle abandons the frame.
        done_cnt = 0;
        cyc(1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 8'h00);
        check("rst_no_done", 64'(done_cnt), 64'd0);
        send_frame(8'h80);
        check("80_frame", last_frame, 64'b10000000100);

        // Start held high: back-to-back frames with one idle gap.
        done_cnt = 0;
        for (int i = 0; i < 3 * (DATA_W + TERM_ZEROS + 2); i++) begin
            cyc(1'b0, 1'b1, 8'h3C);
            if (done === 1'b1) check("3c_parity", {63'd0, last_frame[TERM_ZEROS]}, 64'd0);
        end
        check("3c_frame", last_frame, 64'b00111100000);
        check("3c_dones", 64'(done_cnt), 64'd3);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 8'h00);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), DATA_W'($urandom));
            if (done === 1'b1) begin
                ones = $countones(last_frame);
                check("rand_even_ones", 64'(ones[0]), 64'd0);
                check("rand_len", 64'(last_len), 64'(DATA_W + 1 + TERM_ZEROS));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
